// File: rtl/fm_mod_pkg.sv
// ---------------------------------------------------------------------------
// fm_mod_pkg
// Shared widths, the zero-deviation code point, data typedefs, and the
// elaboration-time builder for the quarter-wave sine ROM used by fm_modulator.
// ---------------------------------------------------------------------------
package fm_mod_pkg;

   localparam int PHASE_W   = 32;
   localparam int LUT_AW    = 8;
   localparam int AMP_W     = 17;
   localparam int OUT_W     = 39;
   localparam int OUT_FRAC  = 36;
   localparam logic [12:0] CENTER = 13'h1000;
   localparam int LUT_DEPTH = 1 << LUT_AW;

   typedef logic [PHASE_W-1:0]            phase_t;
   typedef logic signed [OUT_W-1:0]       iq_t;
   typedef logic [LUT_DEPTH-1:0][AMP_W-1:0] rom_t;

   // round((2^17-1) * sin(pi/2 * (k+0.5)/256)). The Taylor series is carried
   // to x^13; for x <= pi/2 the first dropped term is far below half an LSB.
   function automatic logic [AMP_W-1:0] quarter_sine(input int k);
      real x;
      real term;
      real acc;
      x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(LUT_DEPTH);
      term = x;
      acc  = x;
      for (int n = 1; n < 7; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      return AMP_W'($rtoi(acc * real'((1 << AMP_W) - 1) + 0.5));
   endfunction

   function automatic rom_t build_rom();
      rom_t rom;
      for (int k = 0; k < LUT_DEPTH; k++) begin
         rom[k] = quarter_sine(k);
      end
      return rom;
   endfunction

endpackage

// File: rtl/fm_mod_if.sv
// ---------------------------------------------------------------------------
// fm_mod_if
// Sample-stream bundle for one fm_modulator: the stall/enable and message
// input on the producer side, and the I/Q pair with its valid strobe on the
// modulator side. The modulator keeps flat port names so it drops straight
// into the existing FM loopback; this bundle is what the driving side holds.
//   master : drives clk_enable, in_fm; observes out_I, out_Q, ce_out
//   slave  : the modulator's view
// ---------------------------------------------------------------------------
interface fm_mod_if;
   import fm_mod_pkg::*;

   logic        clk_enable;
   logic [12:0] in_fm;
   iq_t         out_I;
   iq_t         out_Q;
   logic        ce_out;

   modport master (output clk_enable, output in_fm,
                   input  out_I, input out_Q, input ce_out);
   modport slave  (input  clk_enable, input in_fm,
                   output out_I, output out_Q, output ce_out);

endinterface

// File: rtl/fm_sincos_lut.sv
// ---------------------------------------------------------------------------
// fm_sincos_lut
// Quarter-wave sine/cosine generator, two pipeline stages:
//   address stage : quadrant mirroring of the sin and cos addresses and
//                   capture of their negate flags
//   read stage    : two reads of the 256x17 ROM, negation, scaling to
//                   sfix39_En36 (19 zero LSBs)
// Ports:
//   clk, reset (async, active-low), i_ce (stall when low)
//   i_phase : top 10 bits of the phase accumulator (quadrant, index)
//   o_sin, o_cos : registered sfix39_En36 outputs
// ---------------------------------------------------------------------------
module fm_sincos_lut
   import fm_mod_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_ce,
   input  logic [LUT_AW+1:0] i_phase,
   output iq_t               o_sin,
   output iq_t               o_cos
);

   localparam rom_t ROM   = build_rom();
   localparam int   SHIFT = OUT_FRAC - AMP_W;
   localparam int   EXT_W = OUT_W - (AMP_W + 1) - SHIFT;

   logic [1:0]        w_q;
   logic [LUT_AW-1:0] w_i;
   logic [LUT_AW-1:0] r_addr_s;
   logic [LUT_AW-1:0] r_addr_c;
   logic              r_neg_s;
   logic              r_neg_c;
   logic [AMP_W-1:0]  w_mag_s;
   logic [AMP_W-1:0]  w_mag_c;
   iq_t               r_sin;
   iq_t               r_cos;

   function automatic iq_t scale(input logic neg, input logic [AMP_W-1:0] mag);
      logic signed [AMP_W:0] v;
      v = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
      return {{EXT_W{v[AMP_W]}}, v, {SHIFT{1'b0}}};
   endfunction

   assign w_q = i_phase[LUT_AW+1:LUT_AW];
   assign w_i = i_phase[LUT_AW-1:0];

   // Odd quadrants read the table backwards (255-i == ~i). Cosine is the
   // sine of the next quadrant, so its mirror sense is inverted and its
   // sign flips at quadrants 1 and 2.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr_s <= '0;
         r_addr_c <= '0;
         r_neg_s  <= 1'b0;
         r_neg_c  <= 1'b0;
      end else if (i_ce) begin
         r_addr_s <= w_q[0] ? ~w_i : w_i;
         r_addr_c <= w_q[0] ? w_i : ~w_i;
         r_neg_s  <= w_q[1];
         r_neg_c  <= w_q[1] ^ w_q[0];
      end
   end

   assign w_mag_s = ROM[r_addr_s];
   assign w_mag_c = ROM[r_addr_c];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sin <= '0;
         r_cos <= '0;
      end else if (i_ce) begin
         r_sin <= scale(r_neg_s, w_mag_s);
         r_cos <= scale(r_neg_c, w_mag_c);
      end
   end

   assign o_sin = r_sin;
   assign o_cos = r_cos;

endmodule

// File: rtl/fm_modulator.sv
// ---------------------------------------------------------------------------
// fm_modulator
// Baseband-to-I/Q FM modulator. Each enabled clock takes one ufix13_En12
// message sample, scales its deviation from 0x1000 by KDEV, integrates
// FC_WORD plus that deviation into a 32-bit wrapping phase, and emits
// cos/sin of the phase as sfix39_En36 I/Q.
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-low, clears every register
//   clk_enable : global stall; low freezes the whole pipeline
//   in_fm      : message sample, ufix13_En12
//   out_I/out_Q: cosine / sine, sfix39_En36
//   ce_out     : out_I/out_Q valid strobe
// Valid semantics: ce_out is high in a cycle where clk_enable is high and the
// pipeline has filled; each such cycle presents exactly one new sample, and a
// sample held through a stall is presented once, when the stall ends.
// ---------------------------------------------------------------------------
module fm_modulator
   import fm_mod_pkg::*;
#(
   parameter logic [31:0] FC_WORD = 32'h0000_0000,
   parameter logic [15:0] KDEV    = 16'd16384
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic [12:0] in_fm,
   output iq_t         out_I,
   output iq_t         out_Q,
   output logic        ce_out
);

   logic signed [13:0] w_dev;
   logic signed [29:0] w_prod;
   logic signed [29:0] r_prod;
   phase_t             w_incr;
   phase_t             r_phase;
   logic [3:0]         r_fill;
   logic               w_unused_phase_lsbs;

   // |dev| <= 4096 and KDEV < 2^16, so the product always fits 30 signed bits.
   assign w_dev  = $signed({1'b0, in_fm} - {1'b0, CENTER});
   assign w_prod = 30'(w_dev) * 30'($signed({1'b0, KDEV}));
   assign w_incr = FC_WORD + {{(PHASE_W-30){r_prod[29]}}, r_prod};

   // r_fill walks a 1 through the four stages. The accumulator is held at 0
   // until the product stage carries a real sample, so the first output uses
   // phase 0; r_fill[3] is the sticky primed flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prod  <= '0;
         r_phase <= '0;
         r_fill  <= '0;
      end else if (clk_enable) begin
         r_prod <= w_prod;
         r_fill <= {r_fill[2:0], 1'b1};
         if (r_fill[1]) begin
            r_phase <= r_phase + w_incr;
         end
      end
   end

   // Only the top 10 phase bits address the table; the rest is pure
   // accumulator precision.
   assign w_unused_phase_lsbs = ^r_phase[PHASE_W-LUT_AW-3:0];

   fm_sincos_lut u_lut (
      .clk     (clk),
      .reset   (reset),
      .i_ce    (clk_enable),
      .i_phase (r_phase[PHASE_W-1:PHASE_W-LUT_AW-2]),
      .o_sin   (out_Q),
      .o_cos   (out_I)
   );

   assign ce_out = clk_enable & r_fill[3];

endmodule

// File: tb/tb_fm_modulator.sv
// ---------------------------------------------------------------------------
// tb_fm_modulator
// Two modulators share clock, reset and stimulus: dut_a with FC_WORD = 0 and
// dut_b with FC_WORD = 2^30 (quarter-rate carrier). Expected I/Q pairs come
// from hand-computed table entries T[0]=402, T[15]=12447, T[240]=130479,
// T[255]=131070 and are queued as each enabled cycle is issued; a monitor
// pops and compares whenever ce_out is high.
// ---------------------------------------------------------------------------
module tb_fm_modulator;
   import fm_mod_pkg::*;

   logic clk;
   logic rst_n;

   fm_mod_if u_if_a ();
   fm_mod_if u_if_b ();

   fm_modulator #(.FC_WORD(32'h0000_0000), .KDEV(16'd16384)) u_dut_a (
      .clk        (clk),
      .reset      (rst_n),
      .clk_enable (u_if_a.clk_enable),
      .in_fm      (u_if_a.in_fm),
      .out_I      (u_if_a.out_I),
      .out_Q      (u_if_a.out_Q),
      .ce_out     (u_if_a.ce_out)
   );

   fm_modulator #(.FC_WORD(32'h4000_0000), .KDEV(16'd16384)) u_dut_b (
      .clk        (clk),
      .reset      (rst_n),
      .clk_enable (u_if_b.clk_enable),
      .in_fm      (u_if_b.in_fm),
      .out_I      (u_if_b.out_I),
      .out_Q      (u_if_b.out_Q),
      .ce_out     (u_if_b.ce_out)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [77:0] exp_a_q[$];
   logic [77:0] exp_b_q[$];
   logic [77:0] last_a;
   logic [77:0] last_b;
   int          model_edges;
   int          seg_kind;   // 0: in_fm = 0x1000, 1: in_fm = 0x0000

   function automatic logic [77:0] pack_iq(input int i_amp, input int q_amp);
      logic signed [38:0] vi;
      logic signed [38:0] vq;
      vi = 39'(i_amp) <<< 19;
      vq = 39'(q_amp) <<< 19;
      return {vi, vq};
   endfunction

   // FC = 0: zero deviation stays at phase 0; with in_fm = 0 the second
   // sample sits at 0xFC00_0000 (q3, i240): Q = -T[15], I = T[240].
   function automatic logic [77:0] exp_a(input int kind, input int n);
      if (kind == 1 && n == 1) return pack_iq(130479, -12447);
      return pack_iq(131070, 402);
   endfunction

   // FC = 2^30: quarter steps through the four quadrants at index 0; with
   // in_fm = 0 the second sample is at 0x3C00_0000 (q0, i240).
   function automatic logic [77:0] exp_b(input int kind, input int n);
      if (kind == 1) return (n == 1) ? pack_iq(12447, 130479) : pack_iq(131070, 402);
      case (n % 4)
         0:       return pack_iq(131070, 402);
         1:       return pack_iq(-402, 131070);
         2:       return pack_iq(-131070, -402);
         default: return pack_iq(402, -131070);
      endcase
   endfunction

   task automatic check_iq(input string name, input logic [77:0] got, input logic [77:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got I=%0d Q=%0d, want I=%0d Q=%0d", name,
                  $signed(got[77:39]), $signed(got[38:0]),
                  $signed(want[77:39]), $signed(want[38:0]));
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b, want %b", name, got, want);
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
         errors++;
         $display("FAIL %s: pending samples a=%0d b=%0d, want 0", name,
                  exp_a_q.size(), exp_b_q.size());
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (u_if_a.ce_out === 1'b1) begin
         if (exp_a_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut_a unexpected sample: got I=%0d Q=%0d, want none",
                     u_if_a.out_I, u_if_a.out_Q);
         end else begin
            check_iq("dut_a sample", {u_if_a.out_I, u_if_a.out_Q}, exp_a_q.pop_front());
         end
      end
      if (u_if_b.ce_out === 1'b1) begin
         if (exp_b_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut_b unexpected sample: got I=%0d Q=%0d, want none",
                     u_if_b.out_I, u_if_b.out_Q);
         end else begin
            check_iq("dut_b sample", {u_if_b.out_I, u_if_b.out_Q}, exp_b_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic en, input logic [12:0] fm);
      u_if_a.clk_enable = en;
      u_if_a.in_fm      = fm;
      u_if_b.clk_enable = en;
      u_if_b.in_fm      = fm;
   endtask

   // Sets inputs for the next rising edge; an enabled edge from the 4th on
   // produces output sample model_edges-4.
   task automatic cycle(input logic en, input logic [12:0] fm);
      @(posedge clk);
      #1;
      drive(en, fm);
      if (en) begin
         model_edges++;
         if (model_edges >= 4) begin
            last_a = exp_a(seg_kind, model_edges - 4);
            last_b = exp_b(seg_kind, model_edges - 4);
            exp_a_q.push_back(last_a);
            exp_b_q.push_back(last_b);
         end
      end
   endtask

   task automatic stall_check();
      #2;
      check_bit("stall ce_out a", u_if_a.ce_out, 1'b0);
      check_bit("stall ce_out b", u_if_b.ce_out, 1'b0);
      check_iq("stall hold a", {u_if_a.out_I, u_if_a.out_Q}, last_a);
      check_iq("stall hold b", {u_if_b.out_I, u_if_b.out_Q}, last_b);
   endtask

   task automatic check_reset_state(input string tag);
      check_iq({tag, " a"}, {u_if_a.out_I, u_if_a.out_Q}, 78'd0);
      check_iq({tag, " b"}, {u_if_b.out_I, u_if_b.out_Q}, 78'd0);
      check_bit({tag, " ce_out a"}, u_if_a.ce_out, 1'b0);
      check_bit({tag, " ce_out b"}, u_if_b.ce_out, 1'b0);
   endtask

   // Lets the last issued edge happen and be observed, then pulses reset
   // for one clock in the middle of a cycle.
   task automatic reset_mid(input string tag);
      @(posedge clk);
      @(negedge clk);
      #2;
      check_drained({tag, " drained"});
      rst_n = 1'b0;
      #1;
      check_reset_state({tag, " async reset"});
      drive(1'b0, 13'h1000);
      @(negedge clk);
      #2;
      rst_n       = 1'b1;
      model_edges = 0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n       = 1'b1;
      model_edges = 0;
      seg_kind    = 0;
      last_a      = '0;
      last_b      = '0;
      drive(1'b0, 13'h1000);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_state("power-on reset");
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      // Zero deviation, with a 3-cycle stall after sample 2.
      for (int k = 0; k < 6; k++) cycle(1'b1, 13'h1000);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 13'h1000);
         stall_check();
      end
      for (int k = 0; k < 4; k++) cycle(1'b1, 13'h1000);
      reset_mid("after stall run");

      // Quarter-rate run broken by a mid-stream reset, then restart at phase 0.
      for (int k = 0; k < 7; k++) cycle(1'b1, 13'h1000);
      reset_mid("mid-stream");
      for (int k = 0; k < 6; k++) cycle(1'b1, 13'h1000);
      reset_mid("after restart");

      // Full negative deviation: two samples.
      seg_kind = 1;
      for (int k = 0; k < 5; k++) cycle(1'b1, 13'h0000);
      @(posedge clk);
      @(negedge clk);
      #2;
      drive(1'b0, 13'h1000);
      check_drained("final drained");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fm_modulator.md
# fm_modulator

Baseband-to-I/Q FM modulator, the transmit-side counterpart of the FM demodulator. It accepts one unsigned message sample per enabled clock and integrates the frequency deviation into a 32-bit phase accumulator. A quarter-wave sine/cosine lookup turns the phase into I/Q samples in the same sfix39_En36 format the demodulator consumes, so `fm_modulator` → `FM_demodulator` forms a loopback path.

## Interface
Parameters:
- FC_WORD, 32'h0000_0000: carrier phase increment per sample, unsigned, mod 2^32.
- KDEV, 16'd16384: deviation gain, unsigned; scales the signed deviation into phase-increment units.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; every register is cleared while it is low.
- clk_enable  in  1  global stall; when low, no register changes.
- in_fm  in  13  message sample, ufix13_En12; 0x1000 is zero deviation.
- out_I  out  39  cosine output, sfix39_En36.
- out_Q  out  39  sine output, sfix39_En36.
- ce_out  out  1  out_I/out_Q valid strobe.

## Operation
- Deviation: dev = signed14(in_fm − 0x1000), range −4096..+4095.
- Increment: incr = FC_WORD + sign-extend32(dev × KDEV). The product is signed 30-bit; the add is mod 2^32.
- Phase: phase ← phase + incr. The wrap-around of the accumulator is intentional; there is no saturation.
- Output sample n uses Φn = Σ incr(0..n−1), so Φ0 = 0.
- Quantisation: p = Φ[31:22] is truncated, with no rounding. Quadrant q = p[9:8], index i = p[7:0].
- Table: T[k] = round((2^17−1)·sin(π/2·(k+0.5)/256)), k = 0..255, unsigned 17-bit. The half-sample offset makes every quadrant symmetric.
- sin(q,i): q0 → T[i], q1 → T[255−i], q2 → −T[i], q3 → −T[255−i].
- cos uses quadrant q+1 (mod 4) with the same i.
- Output scaling: the result is sfix18_En17, sign-extended and shifted left by 19 to give sfix39_En36. The 19 LSBs are always 0.
- out_Q = sin, out_I = cos.

## Timing
- Pipeline of 4 enabled stages:
  - S1: register dev × KDEV.
  - S2: phase accumulate, presenting Φn.
  - S3: register q, i and the mirrored addresses.
  - S4: LUT read, negate, register outputs.
- Latency: in_fm sampled on enabled edge k affects the output phase of the sample after it. The first output (Φ0) appears after 4 enabled edges.
- clk_enable low: the whole pipeline freezes and outputs hold. No sample is lost or duplicated.
- ce_out = clk_enable AND primed. primed is set on the 4th enabled edge after reset and stays set.
- Reset values: out_I = 0, out_Q = 0, ce_out = 0, phase = 0, primed = 0, all pipeline registers = 0.
- Reset asserted mid-stream clears everything. After release the phase restarts at 0 and requires 4 more enabled edges to re-prime.
- in_fm = 0x1FFF gives dev = +4095 with no overflow. KDEV·dev is at most 2^28, which fits in 30 bits.

## Structure
- Package fm_mod_pkg holds:
  - PHASE_W = 32, LUT_AW = 8, AMP_W = 17, OUT_W = 39, OUT_FRAC = 36, CENTER = 13'h1000.
  - Typedefs phase_t and iq_t.
- Sub-module fm_sincos_lut holds the 256×17 quarter-wave ROM with two read ports (sin and cos addresses) and one registered read stage. It performs the quadrant mirroring and negation so the top level holds only the S1/S2 arithmetic and the control logic.

## Test plan
- Reset state: FC_WORD = 0, in_fm = 0x1000, 6 enabled cycles.
  - ce_out rises on the 4th enabled edge.
  - out_I = 131070·2^19 and out_Q = 402·2^19, holding constant.
- Quarter-rate carrier: FC_WORD = 2^30, in_fm = 0x1000. (out_I, out_Q)/2^19 cycles through (131070, 402), (−402, 131070), (−131070, −402), (402, −131070).
- Negative deviation: FC_WORD = 0, KDEV = 16384, in_fm = 0x0000.
  - The second valid sample has Φ = 0xFC00_0000.
  - out_Q = −T[15]·2^19 and out_I = T[240]·2^19.
- Stall: toggle clk_enable low for 3 cycles mid-stream.
  - Outputs and ce_out freeze; ce_out = 0 during the stall.
  - After resuming, the sample sequence is identical to an unstalled run.
- Mid-stream reset: pulse reset low for 1 cycle during the quarter-rate test.
  - All outputs go to 0 asynchronously.
  - After release the sequence restarts at Φ0 after 4 enabled edges.
- Loopback: drive a 1 kHz tone into fm_modulator → FM_demodulator. The demodulated out_fm tracks in_fm within ±2 LSB after group delay.
